mlp_host_seq: RTL and testbench

//  Host-side initiator for the MLP accelerator control handshake; mlp_fsm is the responder.

---
 rtl/mlp_pkg.sv | 15 +
 rtl/mlp_watchdog.sv | 28 ++
 rtl/mlp_host_seq.sv | 187 ++++++++++++++++++
 tb/tb_mlp_host_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Types and constants shared by the MLP host sequencer and the mlp_fsm responder.
package mlp_pkg;

  localparam int MLP_W_ADDR_W = 11;
  localparam int MLP_X_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT_REQ,
    START_REQ,
    RUN_WAIT,
    DONE
  } host_state_e;

endpackage

// File: rtl/mlp_watchdog.sv
// Loadable down-counter that flags when a single wait has lasted TIMEOUT_CYC cycles.
module mlp_watchdog import mlp_pkg::*; #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic reload_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_count;

  // Loaded on state entry, so the count reaches zero in the TIMEOUT_CYC-th cycle of a wait.
  always_ff @(posedge clk_i) begin
    if (rst_i || reload_i) begin
      r_count <= RELOAD;
    end else if (en_i && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign expired_o = en_i && (r_count == '0);

endmodule

// File: rtl/mlp_host_seq.sv
// Host-side batch sequencer driving the mlp_fsm init/start/result handshake.
// Optional batch latency counter enabled by defining MLP_HOST_PERF_EN.
module mlp_host_seq import mlp_pkg::*; #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_init_i,
  input  logic [CNT_W-1:0] cmd_jobs_i,
  output logic             init_valid_o,
  input  logic             init_ready_i,
  output logic             start_valid_o,
  input  logic             start_ready_i,
  input  logic             result_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] jobs_done_o,
  output logic [31:0]      perf_cycles_o
);

  host_state_e      r_state;
  logic             r_cmd_ready;
  logic             r_init_valid;
  logic             r_start_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_jobs;
  logic [CNT_W-1:0] r_jobs_done;

  logic             w_init_xfer;
  logic             w_start_xfer;
  logic             w_result;
  logic             w_wait;
  logic             w_reload;
  logic             w_expired;
  logic             w_abort;
  logic [CNT_W-1:0] w_jobs_next;

  assign w_init_xfer  = (r_state == INIT_REQ) && init_ready_i;
  assign w_start_xfer = (r_state == START_REQ) && start_ready_i;
  assign w_result     = (r_state == RUN_WAIT) && result_valid_i;
  assign w_wait       = (r_state == INIT_REQ) || (r_state == START_REQ) || (r_state == RUN_WAIT);
  assign w_reload     = !w_wait || w_init_xfer || w_start_xfer || w_result;
  assign w_abort      = w_expired && !(w_init_xfer || w_start_xfer || w_result);
  assign w_jobs_next  = r_jobs_done + CNT_W'(1);

  mlp_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .reload_i (w_reload),
    .en_i     (w_wait),
    .expired_o(w_expired)
  );

  // A handshake in the expiry cycle takes priority, so abort only fires on a stalled wait.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b1;
      r_init_valid  <= 1'b0;
      r_start_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_jobs        <= '0;
      r_jobs_done   <= '0;
    end else if (w_abort) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b1;
      r_init_valid  <= 1'b0;
      r_start_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_jobs      <= cmd_jobs_i;
            r_jobs_done <= '0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_init_i) begin
              r_state      <= INIT_REQ;
              r_init_valid <= 1'b1;
            end else if (cmd_jobs_i != '0) begin
              r_state       <= START_REQ;
              r_start_valid <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        INIT_REQ: begin
          if (init_ready_i) begin
            r_init_valid <= 1'b0;
            if (r_jobs != '0) begin
              r_state       <= START_REQ;
              r_start_valid <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        START_REQ: begin
          if (start_ready_i) begin
            r_state       <= RUN_WAIT;
            r_start_valid <= 1'b0;
          end
        end
        RUN_WAIT: begin
          if (result_valid_i) begin
            r_jobs_done <= w_jobs_next;
            if (w_jobs_next == r_jobs) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state       <= START_REQ;
              r_start_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state       <= IDLE;
          r_cmd_ready   <= 1'b1;
          r_init_valid  <= 1'b0;
          r_start_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o   = r_cmd_ready;
  assign init_valid_o  = r_init_valid;
  assign start_valid_o = r_start_valid;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_timeout_o = r_err;
  assign jobs_done_o   = r_jobs_done;

`ifdef MLP_HOST_PERF_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_perf_out;
  logic [31:0] w_perf_inc;

  assign w_perf_inc = (r_perf_cnt == '1) ? r_perf_cnt : r_perf_cnt + 32'd1;

  // The DONE cycle itself is part of the batch, hence the published value is the incremented count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_cnt <= '0;
      r_perf_out <= '0;
    end else begin
      if ((r_state == IDLE) && cmd_valid_i) begin
        r_perf_cnt <= '0;
      end else if (r_busy) begin
        r_perf_cnt <= w_perf_inc;
      end
      if (r_state == DONE) begin
        r_perf_out <= w_perf_inc;
      end
    end
  end

  assign perf_cycles_o = r_perf_out;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mlp_host_seq.sv
// Bench for mlp_host_seq: plays the mlp_fsm responder with random delays and predicts
// every output from the batch protocol (phases, transfer counts, busy-cycle totals).
module tb_mlp_host_seq;

  localparam int CNT_W = 16;
  localparam int TMO   = 16;
`ifdef MLP_HOST_PERF_EN
  localparam logic [31:0] PERF_MASK = '1;
`else
  localparam logic [31:0] PERF_MASK = '0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_init_i;
  logic [CNT_W-1:0] cmd_jobs_i;
  logic             init_valid_o;
  logic             init_ready_i;
  logic             start_valid_o;
  logic             start_ready_i;
  logic             result_valid_i;
  logic             busy_o;
  logic             done_o;
  logic             err_timeout_o;
  logic [CNT_W-1:0] jobs_done_o;
  logic [31:0]      perf_cycles_o;

  logic [4:0]  ctrlBits;
  int          errors  = 0;
  int          checks  = 0;
  logic [31:0] expPerf = '0;

  assign ctrlBits = {init_valid_o, start_valid_o, busy_o, done_o, cmd_ready_o};

  always #5 clk_i = ~clk_i;

  mlp_host_seq #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_init_i    (cmd_init_i),
    .cmd_jobs_i    (cmd_jobs_i),
    .init_valid_o  (init_valid_o),
    .init_ready_i  (init_ready_i),
    .start_valid_o (start_valid_o),
    .start_ready_i (start_ready_i),
    .result_valid_i(result_valid_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_timeout_o (err_timeout_o),
    .jobs_done_o   (jobs_done_o),
    .perf_cycles_o (perf_cycles_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pickDly(input int fixedDly);
    return (fixedDly < 0) ? int'($urandom_range(4, 0)) : fixedDly;
  endfunction

  task automatic clearInputs();
    init_ready_i   = 1'b0;
    start_ready_i  = 1'b0;
    result_valid_i = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first post-accept cycle.
  task automatic acceptCmd(input logic init, input int jobs);
    checkOutput("cmd_ready", ctrlBits, 5'b00001);
    cmd_valid_i = 1'b1;
    cmd_init_i  = init;
    cmd_jobs_i  = CNT_W'(jobs);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_init_i  = 1'($urandom_range(1, 0));
    cmd_jobs_i  = CNT_W'($urandom);
    checkOutput("err_clear", err_timeout_o, 0);
    checkOutput("jobs_clear", jobs_done_o, 0);
  endtask

  // One full batch; each wait phase lasts its delay plus one cycle, the last with the handshake.
  task automatic applyStimulus(input logic init, input int jobs, input int initDly,
                               input int startDly, input int resDly);
    int busyCycles;
    int d;
    busyCycles = 0;
    acceptCmd(init, jobs);
    if (init) begin
      d = pickDly(initDly);
      for (int k = 0; k <= d; k++) begin
        checkOutput("init_wait", ctrlBits, 5'b10100);
        init_ready_i   = (k == d);
        start_ready_i  = 1'($urandom_range(1, 0));
        result_valid_i = 1'($urandom_range(1, 0));
        busyCycles++;
        @(negedge clk_i);
        clearInputs();
      end
    end
    for (int j = 0; j < jobs; j++) begin
      d = pickDly(startDly);
      for (int k = 0; k <= d; k++) begin
        checkOutput("start_wait", ctrlBits, 5'b01100);
        checkOutput("start_jobs", jobs_done_o, j);
        start_ready_i  = (k == d);
        init_ready_i   = 1'($urandom_range(1, 0));
        result_valid_i = (k == d) ? 1'b1 : 1'($urandom_range(1, 0));
        busyCycles++;
        @(negedge clk_i);
        clearInputs();
      end
      d = pickDly(resDly);
      for (int k = 0; k <= d; k++) begin
        checkOutput("run_wait", ctrlBits, 5'b00100);
        checkOutput("run_jobs", jobs_done_o, j);
        result_valid_i = (k == d);
        start_ready_i  = 1'($urandom_range(1, 0));
        init_ready_i   = 1'($urandom_range(1, 0));
        busyCycles++;
        @(negedge clk_i);
        clearInputs();
      end
    end
    busyCycles++;
    checkOutput("done_pulse", ctrlBits, 5'b00110);
    checkOutput("done_jobs", jobs_done_o, jobs);
    @(negedge clk_i);
    expPerf = 32'(busyCycles) & PERF_MASK;
    checkOutput("post_done", ctrlBits, 5'b00001);
    checkOutput("post_jobs", jobs_done_o, jobs);
    checkOutput("post_err", err_timeout_o, 0);
    checkOutput("perf", perf_cycles_o, expPerf);
  endtask

  // phase 0: stall in init, 1: stall in start, 2: stall waiting for the result.
  task automatic runTimeout(input int phase);
    logic [4:0] waitBits;
    acceptCmd(phase == 0, (phase == 2) ? 1 : 2);
    if (phase == 2) begin
      checkOutput("tmo_start", ctrlBits, 5'b01100);
      start_ready_i = 1'b1;
      @(negedge clk_i);
      clearInputs();
    end
    waitBits = (phase == 0) ? 5'b10100 : (phase == 1) ? 5'b01100 : 5'b00100;
    for (int k = 0; k < TMO; k++) begin
      checkOutput("tmo_wait", ctrlBits, waitBits);
      checkOutput("tmo_err_low", err_timeout_o, 0);
      @(negedge clk_i);
    end
    checkOutput("tmo_abort", ctrlBits, 5'b00001);
    checkOutput("tmo_err", err_timeout_o, 1);
    checkOutput("tmo_jobs", jobs_done_o, 0);
    checkOutput("tmo_perf", perf_cycles_o, expPerf);
    @(negedge clk_i);
    checkOutput("tmo_idle", ctrlBits, 5'b00001);
    checkOutput("tmo_sticky", err_timeout_o, 1);
  endtask

  task automatic runResetMidBatch();
    acceptCmd(1'b0, 4);
    checkOutput("rst_start1", ctrlBits, 5'b01100);
    start_ready_i = 1'b1;
    @(negedge clk_i);
    clearInputs();
    checkOutput("rst_run1", ctrlBits, 5'b00100);
    result_valid_i = 1'b1;
    @(negedge clk_i);
    clearInputs();
    checkOutput("rst_start2", ctrlBits, 5'b01100);
    start_ready_i = 1'b1;
    @(negedge clk_i);
    clearInputs();
    checkOutput("rst_run2", ctrlBits, 5'b00100);
    checkOutput("rst_run2_jobs", jobs_done_o, 1);
    rst_i          = 1'b1;
    result_valid_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    clearInputs();
    expPerf = '0;
    checkOutput("rst_ctrl", ctrlBits, 5'b00001);
    checkOutput("rst_jobs", jobs_done_o, 0);
    checkOutput("rst_err", err_timeout_o, 0);
    checkOutput("rst_perf", perf_cycles_o, 0);
    for (int k = 0; k < 3; k++) begin
      result_valid_i = 1'b1;
      start_ready_i  = 1'($urandom_range(1, 0));
      @(negedge clk_i);
      clearInputs();
      checkOutput("rst_quiet", ctrlBits, 5'b00001);
      checkOutput("rst_quiet_jobs", jobs_done_o, 0);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_init_i  = 1'b0;
    cmd_jobs_i  = '0;
    clearInputs();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("reset_ctrl", ctrlBits, 5'b00001);
    checkOutput("reset_jobs", jobs_done_o, 0);
    checkOutput("reset_err", err_timeout_o, 0);
    checkOutput("reset_perf", perf_cycles_o, 0);

    applyStimulus(1'b1, 3, 0, 0, 1);
    applyStimulus(1'b0, 0, -1, -1, -1);

    result_valid_i = 1'b1;
    @(negedge clk_i);
    clearInputs();
    checkOutput("idle_result", jobs_done_o, 0);

    runTimeout(1);
    applyStimulus(1'b0, 2, -1, -1, -1);
    runTimeout(0);
    runTimeout(2);
    applyStimulus(1'b1, 1, TMO - 1, TMO - 1, TMO - 1);

    runResetMidBatch();

    applyStimulus(1'b0, 1, 0, 0, 5);
    checkOutput("perf_fixed", perf_cycles_o, 32'd8 & PERF_MASK);

    for (int n = 0; n < 25; n++) begin
      applyStimulus(1'($urandom_range(1, 0)), int'($urandom_range(5, 0)), -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no end of run, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
